// File: rtl/sine_wave_anim_pkg.sv
// Shared constants for the animated sine tile layer: quarter-wave heights,
// trail palette, colour constants, mode encodings and the palette-index helper.
package sine_anim_pkg;

    localparam int H_W    = 4;
    localparam int PAL_N  = 7;

    localparam logic [H_W-1:0] H_TAB [0:15] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
        4'd7, 4'd8, 4'd9, 4'd9, 4'd10, 4'd10, 4'd10, 4'd10
    };

    localparam logic [5:0] PAL [0:PAL_N-1] = '{
        6'b11_00_00, 6'b11_10_00, 6'b11_11_00, 6'b00_11_00,
        6'b00_10_11, 6'b00_00_11, 6'b10_00_11
    };

    localparam logic [5:0] WHITE = 6'b11_11_11;
    localparam logic [5:0] BLACK = 6'b00_00_00;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_SCROLL = 2'd1,
        MODE_CYCLE  = 2'd2,
        MODE_BOTH   = 2'd3
    } mode_e;

    // (dm1 + rot) mod 7 for dm1 in 0..14, rot in 0..6: at most two subtracts.
    function automatic logic [2:0] pal_idx(input logic [3:0] dm1, input logic [2:0] rot);
        logic [4:0] a;
        a = 5'(dm1) + 5'(rot);
        if (a >= 5'd14)     a = a - 5'd14;
        else if (a >= 5'd7) a = a - 5'd7;
        return a[2:0];
    endfunction

endpackage

// File: rtl/sine_wave_anim_if.sv
// Tile stream between the coordinate generator (master) and the sine layer (slave).
interface sine_wave_anim_if #(
    parameter int X_W = 6,
    parameter int Y_W = 5
);
    logic           in_valid;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           out_valid;
    logic [5:0]     sine_rgb;

    modport master (output in_valid, x, y, input out_valid, sine_rgb);
    modport slave  (input in_valid, x, y, output out_valid, sine_rgb);
endinterface

// File: rtl/sine_wave_anim_qsine_rom.sv
// Combinational quarter-sine height table, index -> H[index].
module qsine_rom
    import sine_anim_pkg::*;
#(
    parameter int QLEN = 16,
    parameter int IW   = $clog2(QLEN)
) (
    input  logic [IW-1:0]  i,
    output logic [H_W-1:0] h
);
    assign h = H_TAB[i];
endmodule

// File: rtl/sine_wave_anim.sv
// Animated sine tile layer: per-frame scroll/palette state plus a fixed
// two-stage pixel pipeline (curve row lookup, then distance -> colour).
module sine_wave_anim
    import sine_anim_pkg::*;
#(
    parameter int X_W       = 6,
    parameter int Y_W       = 5,
    parameter int QLEN      = 16,
    parameter int CENTRE    = 11,
    parameter int TRAIL_LEN = 7,
    parameter int SPEED_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               frame_tick,
    input  logic [1:0]         mode,
    input  logic [SPEED_W-1:0] speed,
    input  logic [1:0]         amp_shift,
    sine_wave_anim_if.slave    tile,
    output logic [X_W-1:0]     phase
);
    localparam int IW = X_W - 2;
    localparam int RW = Y_W + 1;

    logic [X_W-1:0] phase_q, phase_d;
    logic [2:0]     pal_rot_q, pal_rot_d;
    logic           v1_q, v1_d;
    logic [RW-1:0]  row1_q, row1_d;
    logic [Y_W-1:0] y1_q, y1_d;
    logic [2:0]     rot1_q, rot1_d;
    logic           out_valid_q, out_valid_d;
    logic [5:0]     rgb_q, rgb_d;

    logic [X_W-1:0] c;
    logic [1:0]     q;
    logic [IW-1:0]  rom_i;
    logic [H_W-1:0] hq, hs;
    logic [RW-1:0]  y_ext, d;

    assign c     = tile.x + phase_q;
    assign q     = c[X_W-1:X_W-2];
    assign rom_i = q[0] ? (IW'(QLEN - 1) - c[IW-1:0]) : c[IW-1:0];

    qsine_rom #(.QLEN(QLEN), .IW(IW)) u_rom (.i(rom_i), .h(hq));

    assign hs    = hq >> amp_shift;
    assign y_ext = {1'b0, y1_q};
    assign d     = (y_ext >= row1_q) ? (y_ext - row1_q) : (row1_q - y_ext);

    always_comb begin
        phase_d   = phase_q;
        pal_rot_d = pal_rot_q;
        if (frame_tick && ena) begin
            if (mode[0]) phase_d = phase_q + X_W'(speed);
            if (mode[1]) pal_rot_d = (pal_rot_q == 3'd6) ? 3'd0 : pal_rot_q + 3'd1;
        end

        // Stage 1 sees the pre-update phase, so a coincident frame_tick affects the next tile.
        v1_d   = tile.in_valid && ena;
        row1_d = q[1] ? (RW'(CENTRE) + RW'(hs)) : (RW'(CENTRE) - RW'(hs));
        y1_d   = tile.y;
        rot1_d = pal_rot_q;

        out_valid_d = v1_q && ena;
        rgb_d       = BLACK;
        if (out_valid_d) begin
            if (d == '0)                   rgb_d = WHITE;
            else if (d <= RW'(TRAIL_LEN))  rgb_d = PAL[pal_idx(4'(d - RW'(1)), rot1_q)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            pal_rot_q   <= '0;
            v1_q        <= 1'b0;
            row1_q      <= '0;
            y1_q        <= '0;
            rot1_q      <= '0;
            out_valid_q <= 1'b0;
            rgb_q       <= BLACK;
        end else begin
            phase_q     <= phase_d;
            pal_rot_q   <= pal_rot_d;
            v1_q        <= v1_d;
            row1_q      <= row1_d;
            y1_q        <= y1_d;
            rot1_q      <= rot1_d;
            out_valid_q <= out_valid_d;
            rgb_q       <= rgb_d;
        end
    end

    assign tile.out_valid = out_valid_q;
    assign tile.sine_rgb  = rgb_q;
    assign phase          = phase_q;
endmodule
